// File: rtl/beat_scan_scheduler_if.sv
// ============================================================================
// Module      : beat_scan_scheduler_if
// Description : Control / status bundle between a frame requester and the
//               beat/pause pixel scan scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface beat_scan_scheduler_if #(
    parameter int unsigned PIXELCOUNTERWIDTH = 20
);
    logic                         start;
    logic                         abort;
    logic                         stall;
    logic                         process;
    logic [PIXELCOUNTERWIDTH-1:0] pixelCounter;
    logic [7:0]                   beatIndex;
    logic                         started;
    logic                         done;

    // Requester side: issues frames, back-pressure and abort.
    modport master (
        output start, abort, stall,
        input  process, pixelCounter, beatIndex, started, done
    );

    // Scheduler side.
    modport slave (
        input  start, abort, stall,
        output process, pixelCounter, beatIndex, started, done
    );
endinterface

`default_nettype wire

// File: rtl/beat_scan_scheduler.sv
// ============================================================================
// Module      : beat_scan_scheduler
// Description : Walks a pixel window [MINPIXEL, MAXPIXEL], issuing BEATS
//               process strobes per pixel separated by PAUSE idle cycles,
//               with stall back-pressure, abort and an end-of-frame pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beat_scan_scheduler #(
    parameter int unsigned PIXELCOUNTERWIDTH = 20,
    parameter int unsigned MINPIXEL          = 0,
    parameter int unsigned MAXPIXEL          = 255,
    parameter int unsigned BEATS             = 4,
    parameter int unsigned PAUSE             = 1
) (
    input  wire                   clk,
    input  wire                   reset,
    beat_scan_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [PIXELCOUNTERWIDTH-1:0] c_MIN_PIXEL = PIXELCOUNTERWIDTH'(MINPIXEL);
    localparam logic [PIXELCOUNTERWIDTH-1:0] c_MAX_PIXEL = PIXELCOUNTERWIDTH'(MAXPIXEL);
    localparam logic [PIXELCOUNTERWIDTH-1:0] c_ONE_PIXEL = PIXELCOUNTERWIDTH'(1);
    localparam logic [7:0]                   c_LAST_BEAT  = 8'(BEATS - 1);
    // Only meaningful when PAUSE > 0; the PAUSE state is unreachable otherwise.
    localparam logic [7:0]                   c_LAST_PAUSE = 8'(PAUSE - 1);
    localparam bit                           c_NO_PAUSE   = (PAUSE == 0);

    state_t                       r_state;
    state_t                       w_stateNext;
    logic [PIXELCOUNTERWIDTH-1:0] r_pixelCounter;
    logic [PIXELCOUNTERWIDTH-1:0] w_pixelNext;
    logic [7:0]                   r_beatIndex;
    logic [7:0]                   w_beatNext;
    logic [7:0]                   r_pauseCnt;
    logic [7:0]                   w_pauseNext;
    logic                         w_process;
    logic                         w_done;

    // State and counter registers; reset dominates start and abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_pixelCounter <= c_MIN_PIXEL;
            r_beatIndex    <= 8'd0;
            r_pauseCnt     <= 8'd0;
        end else begin
            r_state        <= w_stateNext;
            r_pixelCounter <= w_pixelNext;
            r_beatIndex    <= w_beatNext;
            r_pauseCnt     <= w_pauseNext;
        end
    end

    // Next-state, counter update and strobe decode.
    always_comb begin
        w_stateNext = r_state;
        w_pixelNext = r_pixelCounter;
        w_beatNext  = r_beatIndex;
        w_pauseNext = r_pauseCnt;
        w_process   = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_pixelNext = c_MIN_PIXEL;
                w_beatNext  = 8'd0;
                w_pauseNext = 8'd0;
                if (bus.start) begin
                    w_stateNext = ST_BEAT;
                end
            end
            ST_BEAT: begin
                // A stalled beat is simply not consumed; everything holds.
                if (!bus.stall) begin
                    w_process = 1'b1;
                    if (r_beatIndex != c_LAST_BEAT) begin
                        w_beatNext = r_beatIndex + 8'd1;
                    end else if (r_pixelCounter == c_MAX_PIXEL) begin
                        w_stateNext = ST_DONE;
                        w_beatNext  = 8'd0;
                    end else if (c_NO_PAUSE) begin
                        w_pixelNext = r_pixelCounter + c_ONE_PIXEL;
                        w_beatNext  = 8'd0;
                    end else begin
                        w_stateNext = ST_PAUSE;
                        w_pauseNext = 8'd0;
                        w_beatNext  = 8'd0;
                    end
                end
            end
            ST_PAUSE: begin
                if (r_pauseCnt == c_LAST_PAUSE) begin
                    w_pixelNext = r_pixelCounter + c_ONE_PIXEL;
                    w_pauseNext = 8'd0;
                    w_stateNext = ST_BEAT;
                end else begin
                    w_pauseNext = r_pauseCnt + 8'd1;
                end
            end
            ST_DONE: begin
                // pixelCounter still shows MAXPIXEL this cycle.
                w_done      = 1'b1;
                w_stateNext = ST_IDLE;
                w_pixelNext = c_MIN_PIXEL;
                w_beatNext  = 8'd0;
                w_pauseNext = 8'd0;
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_pixelNext = c_MIN_PIXEL;
                w_beatNext  = 8'd0;
                w_pauseNext = 8'd0;
            end
        endcase

        // Abort only redirects the next state; this cycle's strobes stand.
        if (bus.abort && (r_state != ST_IDLE)) begin
            w_stateNext = ST_IDLE;
            w_pixelNext = c_MIN_PIXEL;
            w_beatNext  = 8'd0;
            w_pauseNext = 8'd0;
        end
    end

    assign bus.process      = w_process;
    assign bus.done         = w_done;
    assign bus.started      = (r_state != ST_IDLE);
    assign bus.pixelCounter = r_pixelCounter;
    assign bus.beatIndex    = r_beatIndex;

endmodule

`default_nettype wire

// File: tb/tb_beat_scan_scheduler.sv
// ============================================================================
// Module      : tb_beat_scan_scheduler
// Description : Self-checking bench for beat_scan_scheduler. Three instances
//               (basic, zero-pause, single-pixel window) are driven from a
//               queue of per-cycle vectors built from the frame shape.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beat_scan_scheduler;

    localparam int c_W = 20;

    logic clk;
    logic reset;

    beat_scan_scheduler_if #(.PIXELCOUNTERWIDTH(c_W)) ifA ();
    beat_scan_scheduler_if #(.PIXELCOUNTERWIDTH(c_W)) ifB ();
    beat_scan_scheduler_if #(.PIXELCOUNTERWIDTH(c_W)) ifC ();

    beat_scan_scheduler #(.PIXELCOUNTERWIDTH(c_W), .MINPIXEL(0), .MAXPIXEL(3),
                          .BEATS(4), .PAUSE(1))
        dutA (.clk(clk), .reset(reset), .bus(ifA));

    beat_scan_scheduler #(.PIXELCOUNTERWIDTH(c_W), .MINPIXEL(0), .MAXPIXEL(2),
                          .BEATS(2), .PAUSE(0))
        dutB (.clk(clk), .reset(reset), .bus(ifB));

    beat_scan_scheduler #(.PIXELCOUNTERWIDTH(c_W), .MINPIXEL(5), .MAXPIXEL(5),
                          .BEATS(3), .PAUSE(2))
        dutC (.clk(clk), .reset(reset), .bus(ifC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int dut;
        bit rst;
        bit start;
        bit abort;
        bit stall;
        bit eProcess;
        int ePixel;
        int eBeat;
        bit eStarted;
        bit eDone;
    } vec_t;

    vec_t sb[$];
    int   nCompared = 0;
    int   nMismatch = 0;
    int   vecIdx    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatch++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", nm, vecIdx, act, exp);
        end
    endtask

    task automatic push(input int d, input bit r, input bit s, input bit a, input bit st,
                        input bit ep, input int epix, input int eb, input bit es, input bit ed);
        vec_t v;
        v.dut = d; v.rst = r; v.start = s; v.abort = a; v.stall = st;
        v.eProcess = ep; v.ePixel = epix; v.eBeat = eb; v.eStarted = es; v.eDone = ed;
        sb.push_back(v);
    endtask

    // Expected cycle-by-cycle trace of one frame, from the start cycle on.
    // Negative option values disable the corresponding event.
    task automatic genFrame(input int d, input int minp, input int maxp,
                            input int beats, input int pause,
                            input int stallPix, input int stallBeat, input int stallLen,
                            input int startPix, input int abortPausePix,
                            input bit abortDone, input int resetPix, input int idleAfter);
        int n;
        bit sp;
        bit ab;
        n = maxp - minp + 1;
        push(d, 0, 1, 0, 0, 0, minp, 0, 0, 0);
        for (int p = 0; p < n; p++) begin
            for (int b = 0; b < beats; b++) begin
                sp = (p == startPix) && (b == 0);
                if (p == stallPix && b == stallBeat) begin
                    for (int k = 0; k < stallLen; k++)
                        push(d, 0, 0, 0, 1, 0, minp + p, b, 1, 0);
                end
                if (p == resetPix && b == 0) begin
                    push(d, 1, 1, 0, 0, 1, minp + p, 0, 1, 0);
                    push(d, 0, 0, 0, 0, 0, minp, 0, 0, 0);
                    push(d, 0, 0, 0, 0, 0, minp, 0, 0, 0);
                    return;
                end
                push(d, 0, sp, 0, 0, 1, minp + p, b, 1, 0);
            end
            if (p < n - 1) begin
                for (int k = 0; k < pause; k++) begin
                    ab = (p == abortPausePix) && (k == 0);
                    push(d, 0, 0, ab, 0, 0, minp + p, 0, 1, 0);
                    if (ab) begin
                        push(d, 0, 0, 0, 0, 0, minp, 0, 0, 0);
                        push(d, 0, 0, 0, 0, 0, minp, 0, 0, 0);
                        return;
                    end
                end
            end
        end
        push(d, 0, 0, abortDone, 0, 0, maxp, 0, 1, 1);
        for (int k = 0; k < idleAfter; k++)
            push(d, 0, 0, 0, 0, 0, minp, 0, 0, 0);
    endtask

    task automatic driveIdle();
        ifA.start = 0; ifA.abort = 0; ifA.stall = 0;
        ifB.start = 0; ifB.abort = 0; ifB.stall = 0;
        ifC.start = 0; ifC.abort = 0; ifC.stall = 0;
    endtask

    // Apply queued vectors: drive after posedge, compare at negedge.
    task automatic runQueue();
        vec_t v;
        logic             aProc, aStarted, aDone;
        logic [c_W-1:0]   aPix;
        logic [7:0]       aBeat;
        while (sb.size() > 0) begin
            v = sb.pop_front();
            driveIdle();
            reset = v.rst;
            case (v.dut)
                0: begin ifA.start = v.start; ifA.abort = v.abort; ifA.stall = v.stall; end
                1: begin ifB.start = v.start; ifB.abort = v.abort; ifB.stall = v.stall; end
                default: begin ifC.start = v.start; ifC.abort = v.abort; ifC.stall = v.stall; end
            endcase
            @(negedge clk);
            case (v.dut)
                0: begin aProc = ifA.process; aPix = ifA.pixelCounter; aBeat = ifA.beatIndex;
                         aStarted = ifA.started; aDone = ifA.done; end
                1: begin aProc = ifB.process; aPix = ifB.pixelCounter; aBeat = ifB.beatIndex;
                         aStarted = ifB.started; aDone = ifB.done; end
                default: begin aProc = ifC.process; aPix = ifC.pixelCounter; aBeat = ifC.beatIndex;
                         aStarted = ifC.started; aDone = ifC.done; end
            endcase
            chk("process",      int'(aProc),    int'(v.eProcess));
            chk("pixelCounter", int'(aPix),     v.ePixel);
            chk("beatIndex",    int'(aBeat),    v.eBeat);
            chk("started",      int'(aStarted), int'(v.eStarted));
            chk("done",         int'(aDone),    int'(v.eDone));
            vecIdx++;
            @(posedge clk);
            #1;
        end
        reset = 0;
        driveIdle();
    endtask

    // Post-reset idle state of each instance.
    vec_t resetTab[3];

    initial begin
        resetTab[0] = '{dut: 0, rst: 0, start: 0, abort: 0, stall: 0,
                        eProcess: 0, ePixel: 0, eBeat: 0, eStarted: 0, eDone: 0};
        resetTab[1] = '{dut: 1, rst: 0, start: 0, abort: 0, stall: 1,
                        eProcess: 0, ePixel: 0, eBeat: 0, eStarted: 0, eDone: 0};
        resetTab[2] = '{dut: 2, rst: 0, start: 0, abort: 1, stall: 0,
                        eProcess: 0, ePixel: 5, eBeat: 0, eStarted: 0, eDone: 0};

        reset = 1;
        driveIdle();
        repeat (3) @(posedge clk);
        #1;
        reset = 0;

        for (int i = 0; i < 3; i++) sb.push_back(resetTab[i]);
        runQueue();

        // Basic frame: done 20 cycles after start, then idle.
        genFrame(0, 0, 3, 4, 1, -1, -1, 0, -1, -1, 0, -1, 3);
        runQueue();

        // Three stall cycles at beat 2 of pixel 1: done at cycle 23.
        genFrame(0, 0, 3, 4, 1, 1, 2, 3, -1, -1, 0, -1, 2);
        runQueue();

        // Zero pause: six back-to-back beats, done on cycle 7.
        genFrame(1, 0, 2, 2, 0, -1, -1, 0, -1, -1, 0, -1, 2);
        runQueue();

        // Abort in the pause after pixel 1, then a full clean frame.
        genFrame(0, 0, 3, 4, 1, -1, -1, 0, -1, 1, 0, -1, 0);
        genFrame(0, 0, 3, 4, 1, -1, -1, 0, -1, -1, 0, -1, 2);
        runQueue();

        // Reset together with start during pixel 2.
        genFrame(0, 0, 3, 4, 1, -1, -1, 0, -1, -1, 0, 2, 0);
        runQueue();

        // Start pulse while busy has no effect on timing or follow-on frames.
        genFrame(0, 0, 3, 4, 1, -1, -1, 0, 1, -1, 0, -1, 4);
        runQueue();

        // Abort during DONE still delivers the done pulse.
        genFrame(0, 0, 3, 4, 1, -1, -1, 0, -1, -1, 1, -1, 2);
        runQueue();

        // Single-pixel window: three beats then DONE, no pause.
        genFrame(2, 5, 5, 3, 2, -1, -1, 0, -1, -1, 0, -1, 2);
        runQueue();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    // Hard time limit so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, got %0d vectors, expected completion", vecIdx);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
